// File: rtl/min_max_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : min_max_result_collector
//  Purpose  : Handshakes results from an upstream min/max finder, reports the
//             per-result range and accumulates global max/min, a saturating
//             accepted-result count and a sticky error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module min_max_result_collector #(
    parameter int W     = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done_in,
    input  logic [W-1:0]     max_in,
    input  logic [W-1:0]     min_in,
    input  logic             clr,
    output logic             ack,
    output logic             valid_out,
    output logic [W-1:0]     range_out,
    output logic [W-1:0]     global_max,
    output logic [W-1:0]     global_min,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ACK     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             ack_q, ack_d;
    logic             valid_q, valid_d;
    logic             load_hold;
    logic             do_capture;

    logic [W-1:0]     hold_max_q, hold_max_d;
    logic [W-1:0]     hold_min_q, hold_min_d;
    logic [W-1:0]     range_q, range_d;
    logic [W-1:0]     gmax_q, gmax_d;
    logic [W-1:0]     gmin_q, gmin_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             first_q, first_d;
    logic             accepted;

    // Handshake FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
        end
    end

    // Next-state decode: capture on done, update stats once, then hold ack
    // until upstream drops done.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        valid_d    = 1'b0;
        load_hold  = 1'b0;
        do_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (done_in) begin
                    load_hold = 1'b1;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                valid_d    = 1'b1;
                do_capture = 1'b1;
                state_d    = S_ACK;
            end
            S_ACK: begin
                if (done_in) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A held result with max below min is malformed and only flags err.
    assign accepted = (hold_max_q >= hold_min_q);

    // Holding registers and statistics update; clr outranks a coinciding
    // capture so that result never enters the statistics.
    always_comb begin
        hold_max_d = hold_max_q;
        hold_min_d = hold_min_q;
        range_d    = range_q;
        gmax_d     = gmax_q;
        gmin_d     = gmin_q;
        count_d    = count_q;
        err_d      = err_q;
        first_d    = first_q;

        if (load_hold) begin
            hold_max_d = max_in;
            hold_min_d = min_in;
        end

        if (do_capture) begin
            range_d = accepted ? (hold_max_q - hold_min_q) : '0;
        end

        if (clr) begin
            gmax_d  = '0;
            gmin_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
            first_d = 1'b1;
        end else if (do_capture) begin
            if (accepted) begin
                if (first_q) begin
                    gmax_d = hold_max_q;
                    gmin_d = hold_min_q;
                end else begin
                    gmax_d = (hold_max_q > gmax_q) ? hold_max_q : gmax_q;
                    gmin_d = (hold_min_q < gmin_q) ? hold_min_q : gmin_q;
                end
                first_d = 1'b0;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_ONE;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_max_q <= '0;
            hold_min_q <= '0;
            range_q    <= '0;
            gmax_q     <= '0;
            gmin_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            hold_max_q <= hold_max_d;
            hold_min_q <= hold_min_d;
            range_q    <= range_d;
            gmax_q     <= gmax_d;
            gmin_q     <= gmin_d;
            count_q    <= count_d;
            err_q      <= err_d;
            first_q    <= first_d;
        end
    end

    assign ack        = ack_q;
    assign valid_out  = valid_q;
    assign range_out  = range_q;
    assign global_max = gmax_q;
    assign global_min = gmin_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_min_max_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_min_max_result_collector
//  Purpose  : Self-checking bench for min_max_result_collector. A reference
//             model pushes expected results when a result is offered; a
//             monitor pops and compares them on each valid_out pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_min_max_result_collector;

    logic       clk;
    logic       reset;
    logic       done_in;
    logic [2:0] max_in;
    logic [2:0] min_in;
    logic       clr;
    logic       ack;
    logic       valid_out;
    logic [2:0] range_out;
    logic [2:0] global_max;
    logic [2:0] global_min;
    logic [3:0] count;
    logic       err;

    int total;
    int bad;

    typedef struct {
        logic [2:0] rng;
        logic [2:0] gmax;
        logic [2:0] gmin;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    logic [2:0] m_gmax, m_gmin;
    logic [3:0] m_cnt;
    logic       m_err, m_first;

    min_max_result_collector #(.W(3), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .done_in    (done_in),
        .max_in     (max_in),
        .min_in     (min_in),
        .clr        (clr),
        .ack        (ack),
        .valid_out  (valid_out),
        .range_out  (range_out),
        .global_max (global_max),
        .global_min (global_min),
        .count      (count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every valid_out pulse consumes one expected result.
    always @(negedge clk) begin
        if (!reset && valid_out) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_unexpected_valid: got valid_out=1 required no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (range_out !== e.rng || global_max !== e.gmax || global_min !== e.gmin ||
                    count !== e.cnt || err !== e.err) begin
                    bad = bad + 1;
                    $display("FAIL sb_result: got rng=%0d gmax=%0d gmin=%0d cnt=%0d err=%0b required rng=%0d gmax=%0d gmin=%0d cnt=%0d err=%0b",
                             range_out, global_max, global_min, count, err,
                             e.rng, e.gmax, e.gmin, e.cnt, e.err);
                end
            end
        end
    end

    task automatic model_reset();
        m_gmax = 3'd0; m_gmin = 3'd0; m_cnt = 4'd0; m_err = 1'b0; m_first = 1'b1;
    endtask

    task automatic model_push(input logic [2:0] mx, input logic [2:0] mn, input bit clrcap);
        exp_t e;
        e.rng = (mx >= mn) ? 3'(mx - mn) : 3'd0;
        if (clrcap) begin
            model_reset();
        end else if (mx >= mn) begin
            if (m_first) begin
                m_gmax = mx; m_gmin = mn; m_first = 1'b0;
            end else begin
                if (mx > m_gmax) m_gmax = mx;
                if (mn < m_gmin) m_gmin = mn;
            end
            if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        end else begin
            m_err = 1'b1;
        end
        e.gmax = m_gmax; e.gmin = m_gmin; e.cnt = m_cnt; e.err = m_err;
        sb.push_back(e);
    endtask

    // Called at a negedge with done_in already high and the result pushed.
    task automatic run_from_done(input string tag, input bit clrcap);
        @(posedge clk); @(negedge clk);
        total = total + 1;
        if (ack !== 1'b0 || valid_out !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL %s_capture_phase: got ack=%0b valid=%0b required ack=0 valid=0", tag, ack, valid_out);
        end
        // Inputs wander after capture; the held values must be used.
        max_in = 3'(~max_in);
        min_in = 3'(min_in + 3'd3);
        if (clrcap) clr = 1'b1;
        @(posedge clk); @(negedge clk);
        clr = 1'b0;
        total = total + 1;
        if (ack !== 1'b0 || valid_out !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL %s_valid_phase: got ack=%0b valid=%0b required ack=0 valid=1", tag, ack, valid_out);
        end
        @(posedge clk); @(negedge clk);
        total = total + 1;
        if (ack !== 1'b1 || valid_out !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL %s_ack_phase: got ack=%0b valid=%0b required ack=1 valid=0", tag, ack, valid_out);
        end
        done_in = 1'b0;
        @(posedge clk); @(negedge clk);
        total = total + 1;
        if (ack !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL %s_ack_drop: got ack=%0b required 0", tag, ack);
        end
    endtask

    task automatic send(input string tag, input logic [2:0] mx, input logic [2:0] mn, input bit clrcap);
        max_in = mx; min_in = mn; done_in = 1'b1;
        model_push(mx, mn, clrcap);
        run_from_done(tag, clrcap);
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] rng, input logic [2:0] gmx,
                                 input logic [2:0] gmn, input logic [3:0] cnt, input logic e);
        total = total + 1;
        if (range_out !== rng || global_max !== gmx || global_min !== gmn || count !== cnt || err !== e) begin
            bad = bad + 1;
            $display("FAIL %s: got rng=%0d gmax=%0d gmin=%0d cnt=%0d err=%0b required rng=%0d gmax=%0d gmin=%0d cnt=%0d err=%0b",
                     tag, range_out, global_max, global_min, count, err, rng, gmx, gmn, cnt, e);
        end
    endtask

    task automatic test_reset();
        done_in = 1'b0; clr = 1'b0; max_in = 3'd0; min_in = 3'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        total = total + 1;
        if (ack !== 1'b0 || valid_out !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_handshake: got ack=%0b valid=%0b required 0 0", ack, valid_out);
        end
        check_outputs("reset_stats", 3'd0, 3'd0, 3'd0, 4'd0, 1'b0);
    endtask

    task automatic test_single();
        test_reset();
        send("single", 3'd3, 3'd1, 1'b0);
        check_outputs("single_final", 3'd2, 3'd3, 3'd1, 4'd1, 1'b0);
    endtask

    task automatic test_sequence();
        test_reset();
        send("seq0", 3'd3, 3'd1, 1'b0);
        send("seq1", 3'd2, 3'd1, 1'b0);
        send("seq2", 3'd3, 3'd2, 1'b0);
        send("seq3", 3'd7, 3'd0, 1'b0);
        check_outputs("seq_final", 3'd7, 3'd7, 3'd0, 4'd4, 1'b0);
    endtask

    task automatic test_invalid();
        test_reset();
        send("inv_pre", 3'd3, 3'd1, 1'b0);
        send("inv_bad", 3'd1, 3'd3, 1'b0);
        check_outputs("inv_flag", 3'd0, 3'd3, 3'd1, 4'd1, 1'b1);
        send("inv_post", 3'd6, 3'd2, 1'b0);
        check_outputs("inv_sticky", 3'd4, 3'd6, 3'd1, 4'd2, 1'b1);
    endtask

    task automatic test_saturation();
        logic [2:0] mx, mn;
        test_reset();
        for (int i = 0; i < 17; i++) begin
            mx = 3'($urandom_range(7, 0));
            mn = 3'($urandom_range(int'(mx), 0));
            send("sat", mx, mn, 1'b0);
            if (i == 14) begin
                total = total + 1;
                if (count !== 4'd15) begin
                    bad = bad + 1;
                    $display("FAIL sat_reach15: got count=%0d required 15", count);
                end
            end
        end
        total = total + 1;
        if (count !== 4'd15) begin
            bad = bad + 1;
            $display("FAIL sat_hold15: got count=%0d required 15", count);
        end
    endtask

    task automatic test_clr();
        test_reset();
        send("clr_pre", 3'd6, 3'd1, 1'b0);
        send("clr_bad", 3'd1, 3'd3, 1'b0);
        send("clr_cap", 3'd5, 3'd2, 1'b1);
        check_outputs("clr_dropped", 3'd3, 3'd0, 3'd0, 4'd0, 1'b0);
        send("clr_next", 3'd4, 3'd4, 1'b0);
        check_outputs("clr_reload", 3'd0, 3'd4, 3'd4, 4'd1, 1'b0);
        // Clear while idle leaves range_out alone.
        send("clr_more", 3'd5, 3'd3, 1'b0);
        clr = 1'b1;
        @(posedge clk); @(negedge clk);
        clr = 1'b0;
        model_reset();
        check_outputs("clr_idle", 3'd2, 3'd0, 3'd0, 4'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_reset();
        send("b2b0", 3'd2, 3'd0, 1'b0);
        send("b2b1", 3'd5, 3'd5, 1'b0);
        send("b2b2", 3'd7, 3'd3, 1'b0);
        check_outputs("b2b_final", 3'd4, 3'd7, 3'd0, 4'd3, 1'b0);
    endtask

    task automatic test_reset_mid();
        test_reset();
        max_in = 3'd6; min_in = 3'd2; done_in = 1'b1;
        model_push(3'd6, 3'd2, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total = total + 1;
        if (ack !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL rmid_in_ack: got ack=%0b required 1", ack);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        total = total + 1;
        if (ack !== 1'b0 || valid_out !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL rmid_abort: got ack=%0b valid=%0b required 0 0", ack, valid_out);
        end
        check_outputs("rmid_stats", 3'd0, 3'd0, 3'd0, 4'd0, 1'b0);
        reset = 1'b0;
        model_reset();
        max_in = 3'd5; min_in = 3'd1;
        model_push(3'd5, 3'd1, 1'b0);
        run_from_done("rmid_new", 1'b0);
        check_outputs("rmid_final", 3'd4, 3'd5, 3'd1, 4'd1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        done_in = 1'b0; clr = 1'b0; max_in = 3'd0; min_in = 3'd0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_sequence();
        test_invalid();
        test_saturation();
        test_clr();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL sb_leftover: got %0d pending results required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
